// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
//   arb_state_e : job sequencing states
//   id_width()  : width of a requester index (at least one bit)
package mult_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection, purely combinational.
// Ports:
//   req_i     : pending request levels
//   ptr_i     : index where the search starts (highest priority)
//   win_oh_o  : one-hot winner
//   win_idx_o : binary winner index
//   any_o     : at least one request pending
module rr_picker import mult_arb_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int IW    = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] win_oh_o,
  output logic [IW-1:0]    win_idx_o,
  output logic             any_o
);

  // First pass looks at indices at or above the pointer; the second pass
  // covers the wrap-around and only takes effect if the first found nothing.
  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    any_o     = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!any_o && req_i[j] && (IW'(j) >= ptr_i)) begin
        any_o       = 1'b1;
        win_idx_o   = IW'(j);
        win_oh_o[j] = 1'b1;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!any_o && req_i[j]) begin
        any_o       = 1'b1;
        win_idx_o   = IW'(j);
        win_oh_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one multiplier datapath between N_REQ requesters: round-robin pick,
// operand capture, start pulse, wait for done (with timeout), tagged result.
// Ports:
//   Clk, Reset           : clock, synchronous active-high reset
//   Req, OpA_In, OpB_In  : per-requester request level and packed operands
//   Gnt                  : one-hot pulse when a requester's operands are captured
//   Mul_Start/A/B        : multiplier command interface
//   Mul_Done/Product     : multiplier completion interface
//   Res_Valid/Id/Err     : result pulse, owner and timeout flag
//   Result               : returned product (0 on timeout)
//
// state | meaning
// IDLE  | waiting for any request, captures winner's operands
// GRANT | Gnt pulse to the winner
// ISSUE | Mul_Start pulse, timeout counter cleared
// WAIT  | waiting for Mul_Done or timeout
// RESP  | Res_Valid pulse, pointer advanced past the winner
module mult_share_arbiter import mult_arb_pkg::*; #(
  parameter int N_REQ   = 2,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [N_REQ-1:0]           Req,
  input  logic [N_REQ*WIDTH-1:0]     OpA_In,
  input  logic [N_REQ*WIDTH-1:0]     OpB_In,
  output logic [N_REQ-1:0]           Gnt,
  output logic                       Mul_Start,
  output logic [WIDTH-1:0]           Mul_A,
  output logic [WIDTH-1:0]           Mul_B,
  input  logic                       Mul_Done,
  input  logic [2*WIDTH-1:0]         Mul_Product,
  output logic                       Res_Valid,
  output logic [id_width(N_REQ)-1:0] Res_Id,
  output logic                       Res_Err,
  output logic [2*WIDTH-1:0]         Result
);

  localparam int IW = id_width(N_REQ);
  localparam int CW = $clog2(TIMEOUT);

  arb_state_e         state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      win_q;
  logic [N_REQ-1:0]   gnt_q;
  logic               start_q;
  logic               valid_q;
  logic               err_q;
  logic [IW-1:0]      id_q;
  logic [2*WIDTH-1:0] result_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      cnt_q;

  logic [N_REQ-1:0]   pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
    .req_i     (Req),
    .ptr_i     (ptr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (pick_idx == IW'(j)) begin
        sel_a = OpA_In[j*WIDTH +: WIDTH];
        sel_b = OpB_In[j*WIDTH +: WIDTH];
      end
    end
  end

  // The winner is kept in win_q; Res_Id only changes when a result is
  // produced so it stays paired with Result between responses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      id_q     <= '0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
    end else begin
      gnt_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            win_q   <= pick_idx;
            gnt_q   <= pick_oh;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          start_q <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Done has priority over a timeout landing on the same cycle.
          if (Mul_Done) begin
            result_q <= Mul_Product;
            err_q    <= 1'b0;
            id_q     <= win_q;
            valid_q  <= 1'b1;
            state_q  <= RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            result_q <= '0;
            err_q    <= 1'b1;
            id_q     <= win_q;
            valid_q  <= 1'b1;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          ptr_q   <= (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Gnt       = gnt_q;
  assign Mul_Start = start_q;
  assign Mul_A     = a_q;
  assign Mul_B     = b_q;
  assign Res_Valid = valid_q;
  assign Res_Id    = id_q;
  assign Res_Err   = err_q;
  assign Result    = result_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter with a cycle-counting multiplier model.
module tb_mult_share_arbiter;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int TO = 32;

  localparam int M_FIXED = 0;
  localparam int M_OVR   = 1;
  localparam int M_NEVER = 2;
  localparam int M_RAND  = 3;

  logic           Clk;
  logic           Reset;
  logic [N-1:0]   Req;
  logic [N*W-1:0] OpA_In;
  logic [N*W-1:0] OpB_In;
  logic [N-1:0]   Gnt;
  logic           Mul_Start;
  logic [W-1:0]   Mul_A;
  logic [W-1:0]   Mul_B;
  logic           Mul_Done;
  logic [2*W-1:0] Mul_Product;
  logic           Res_Valid;
  logic [0:0]     Res_Id;
  logic           Res_Err;
  logic [2*W-1:0] Result;

  mult_share_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Req         (Req),
    .OpA_In      (OpA_In),
    .OpB_In      (OpB_In),
    .Gnt         (Gnt),
    .Mul_Start   (Mul_Start),
    .Mul_A       (Mul_A),
    .Mul_B       (Mul_B),
    .Mul_Done    (Mul_Done),
    .Mul_Product (Mul_Product),
    .Res_Valid   (Res_Valid),
    .Res_Id      (Res_Id),
    .Res_Err     (Res_Err),
    .Result      (Result)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // multiplier model state
  int          m_mode = M_FIXED;
  int          m_rem = 0;
  int          m_delay_q[$];
  logic [15:0] m_prod = '0;
  logic [15:0] m_ovr = '0;
  bit          m_to = 1'b0;
  int          start_cyc = 0;

  // per-step observations
  bit          gnt_ev, res_ev;
  logic [1:0]  gnt_val, gnt_req;
  int          gnt_total = 0;
  int          gnt_multi = 0;
  int          res_cyc = 0;

  task automatic mul_tick();
    int d;
    Mul_Done    = 1'b0;
    Mul_Product = 16'($urandom);
    if (Mul_Start === 1'b1) begin
      start_cyc = cyc;
      if (m_mode == M_NEVER) d = 0;
      else if (m_mode == M_RAND) begin
        if (m_delay_q.size() > 0) d = m_delay_q.pop_front();
        else d = int'($urandom_range(1, 35));
      end else d = 17;
      m_rem  = d;
      m_prod = (m_mode == M_OVR) ? m_ovr : 16'(Mul_A) * 16'(Mul_B);
      m_to   = (d == 0) || (d > TO);
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        Mul_Done    = 1'b1;
        Mul_Product = m_prod;
      end
    end
  endtask

  task automatic step();
    logic [1:0] rq;
    rq = Req;
    @(negedge Clk);
    cyc++;
    mul_tick();
    gnt_ev = (Gnt !== 2'b00);
    if (gnt_ev) begin
      gnt_val = Gnt;
      gnt_req = rq;
      gnt_total++;
      if (Gnt != 2'b01 && Gnt != 2'b10) gnt_multi++;
    end
    res_ev = (Res_Valid === 1'b1);
    if (res_ev) res_cyc = cyc;
  endtask

  task automatic wait_ev(input bit want_res, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = want_res ? res_ev : gnt_ev;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Req   = '0;
    step();
    step();
    Reset = 1'b0;
  endtask

  function automatic int rr_ref(input logic [1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    Reset = 1'b1; Req = '0; OpA_In = '0; OpB_In = '0;
    repeat (3) step();
    checks++; if (Gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", Gnt); end
    checks++; if (Mul_Start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", Mul_Start); end
    checks++; if (Res_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", Res_Valid); end
    checks++; if (Res_Err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", Res_Err); end
    checks++; if (Result !== 16'h0) begin errors++; $display("FAIL reset_result: got %h expected 0000", Result); end
    checks++; if (Res_Id !== 1'b0) begin errors++; $display("FAIL reset_id: got %b expected 0", Res_Id); end
    checks++; if ({Mul_A, Mul_B} !== 16'h0) begin errors++; $display("FAIL reset_operands: got %h expected 0000", {Mul_A, Mul_B}); end
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    bit seen;
    m_mode = M_FIXED;
    OpA_In = {8'h00, 8'h07}; OpB_In = {8'h00, 8'h03}; Req = 2'b01;
    step();
    checks++; if (Gnt !== 2'b01) begin errors++; $display("FAIL basic_gnt: got %b expected 01", Gnt); end
    Req = 2'b00;
    step();
    checks++; if (Mul_Start !== 1'b1) begin errors++; $display("FAIL basic_start: got %b expected 1", Mul_Start); end
    checks++; if ({Mul_A, Mul_B} !== 16'h0703) begin errors++; $display("FAIL basic_operands: got %h expected 0703", {Mul_A, Mul_B}); end
    wait_ev(1'b1, 100, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL basic_res_timeout: got none expected Res_Valid"); end
    else begin
      checks++; if (res_cyc - start_cyc != 18) begin errors++; $display("FAIL basic_latency: got %0d expected 18", res_cyc - start_cyc); end
      checks++; if (Res_Id !== 1'b0) begin errors++; $display("FAIL basic_id: got %b expected 0", Res_Id); end
      checks++; if (Result !== 16'h0015) begin errors++; $display("FAIL basic_result: got %h expected 0015", Result); end
      checks++; if (Res_Err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", Res_Err); end
    end
    step();
    checks++; if (Res_Valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %b expected 0", Res_Valid); end
  endtask

  task automatic test_round_robin();
    int ng, nr, last, gm0;
    logic [15:0] exp_r;
    do_reset();
    m_mode = M_FIXED;
    OpA_In = {8'd9, 8'd3}; OpB_In = {8'd11, 8'd5}; Req = 2'b11;
    gm0 = gnt_multi; ng = 0; nr = 0; last = -1;
    for (int c = 0; c < 300 && nr < 4; c++) begin
      step();
      if (gnt_ev) begin
        last = (gnt_val == 2'b10) ? 1 : 0;
        ng++;
        if (ng == 4) Req = 2'b00;
      end
      if (res_ev) begin
        exp_r = (nr % 2 == 0) ? 16'd15 : 16'd99;
        checks++; if (int'(Res_Id) != nr % 2) begin errors++; $display("FAIL rr_order: job %0d got id %0d expected %0d", nr, Res_Id, nr % 2); end
        checks++; if (int'(Res_Id) != last) begin errors++; $display("FAIL rr_id_vs_gnt: got id %0d expected %0d", Res_Id, last); end
        checks++; if (Result !== exp_r) begin errors++; $display("FAIL rr_result: got %h expected %h", Result, exp_r); end
        nr++;
      end
    end
    checks++; if (nr != 4) begin errors++; $display("FAIL rr_jobs: got %0d expected 4", nr); end
    checks++; if (gnt_multi != gm0) begin errors++; $display("FAIL rr_gnt_onehot: got %0d bad grants expected 0", gnt_multi - gm0); end
  endtask

  task automatic test_pass_through();
    bit seen;
    m_mode = M_OVR; m_ovr = 16'hFFFE;
    OpA_In = {8'hFF, 8'h00}; OpB_In = {8'h02, 8'h00}; Req = 2'b10;
    wait_ev(1'b0, 20, seen);
    Req = 2'b00;
    checks++; if (!seen || gnt_val !== 2'b10) begin errors++; $display("FAIL pt_gnt: got %b expected 10", gnt_val); end
    wait_ev(1'b1, 100, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL pt_res_timeout: got none expected Res_Valid"); end
    else begin
      checks++; if (Result !== 16'hFFFE) begin errors++; $display("FAIL pt_result: got %h expected fffe", Result); end
      checks++; if (Res_Id !== 1'b1) begin errors++; $display("FAIL pt_id: got %b expected 1", Res_Id); end
      checks++; if ({Mul_A, Mul_B} !== 16'hFF02) begin errors++; $display("FAIL pt_operands: got %h expected ff02", {Mul_A, Mul_B}); end
    end
    step();
  endtask

  task automatic test_timeout();
    bit seen;
    m_mode = M_NEVER;
    OpA_In = {8'h00, 8'h21}; OpB_In = {8'h00, 8'h04}; Req = 2'b01;
    wait_ev(1'b0, 20, seen);
    Req = 2'b00;
    wait_ev(1'b1, 100, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL to_res_timeout: got none expected Res_Valid"); end
    else begin
      checks++; if (res_cyc - start_cyc != TO + 1) begin errors++; $display("FAIL to_latency: got %0d expected %0d", res_cyc - start_cyc, TO + 1); end
      checks++; if (Res_Err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", Res_Err); end
      checks++; if (Result !== 16'h0) begin errors++; $display("FAIL to_result: got %h expected 0000", Result); end
    end
    step();
    m_mode = M_FIXED;
    OpA_In = {8'h00, 8'h0C}; OpB_In = {8'h00, 8'h0B}; Req = 2'b01;
    wait_ev(1'b0, 20, seen);
    Req = 2'b00;
    wait_ev(1'b1, 100, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL to_next_timeout: got none expected Res_Valid"); end
    else begin
      checks++; if ({Res_Err, Result} !== {1'b0, 16'h0084}) begin errors++; $display("FAIL to_next_result: got %b/%h expected 0/0084", Res_Err, Result); end
    end
    step();
  endtask

  task automatic test_reset_mid_job();
    bit seen;
    int nres;
    do_reset();
    m_mode = M_NEVER;
    OpA_In = {8'h00, 8'h05}; OpB_In = {8'h00, 8'h06}; Req = 2'b01;
    wait_ev(1'b0, 20, seen);
    Req = 2'b00;
    repeat (6) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++;
    if ({Gnt, Mul_Start, Res_Valid, Res_Err, Result, Res_Id, Mul_A, Mul_B} !== 37'h0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h expected 0", {Gnt, Mul_Start, Res_Valid, Res_Err, Result, Res_Id, Mul_A, Mul_B});
    end
    step(); step();
    Mul_Done = 1'b1; Mul_Product = 16'h1234;
    nres = 0;
    repeat (6) begin step(); if (res_ev) nres++; end
    checks++; if (nres != 0) begin errors++; $display("FAIL midrst_late_done: got %0d results expected 0", nres); end
    checks++; if (Result !== 16'h0) begin errors++; $display("FAIL midrst_result: got %h expected 0000", Result); end
    m_mode = M_FIXED;
    Req = 2'b11;
    step();
    checks++; if (Gnt !== 2'b01) begin errors++; $display("FAIL midrst_regrant: got %b expected 01", Gnt); end
    Req = 2'b00;
    wait_ev(1'b1, 100, seen);
    checks++; if (!seen || Result !== 16'h001E) begin errors++; $display("FAIL midrst_job: got %h expected 001e", Result); end
    step();
  endtask

  task automatic test_req_ignored();
    bit seen;
    int g0;
    m_mode = M_FIXED;
    OpA_In = {8'h00, 8'h11}; OpB_In = {8'h00, 8'h05}; Req = 2'b01;
    wait_ev(1'b0, 20, seen);
    g0 = gnt_total;
    OpA_In = {8'h00, 8'hAA};
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      Req = 2'($urandom);
      step();
      seen = res_ev;
    end
    Req = 2'b00;
    checks++;
    if (!seen) begin errors++; $display("FAIL ign_res_timeout: got none expected Res_Valid"); end
    else begin
      checks++; if (gnt_total != g0) begin errors++; $display("FAIL ign_extra_gnt: got %0d expected 0", gnt_total - g0); end
      checks++; if (Mul_A !== 8'h11) begin errors++; $display("FAIL ign_mul_a: got %h expected 11", Mul_A); end
      checks++; if (Result !== 16'h0055) begin errors++; $display("FAIL ign_result: got %h expected 0055", Result); end
    end
    repeat (3) step();
    checks++; if (gnt_total != g0) begin errors++; $display("FAIL ign_after_gnt: got %0d expected 0", gnt_total - g0); end
  endtask

  task automatic test_random();
    logic [7:0]  opa[2], opb[2];
    logic [1:0]  pend, eo;
    logic [15:0] exp_prod, exp_r;
    int          ptr_ref, jobs, w, exp_id;
    bit          in_flight;
    do_reset();
    m_mode = M_RAND;
    m_delay_q = '{1, 32, 33, 17, 2, 31, 35};
    pend = '0; ptr_ref = 0; jobs = 0; in_flight = 1'b0; exp_id = 0; exp_prod = '0;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
    for (int c = 0; c < 4000 && jobs < 40; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          opa[i]  = 8'($urandom);
          opb[i]  = 8'($urandom);
        end
      end
      Req = pend; OpA_In = {opa[1], opa[0]}; OpB_In = {opb[1], opb[0]};
      step();
      if (gnt_ev) begin
        w = rr_ref(gnt_req, ptr_ref);
        eo = '0;
        if (w >= 0) eo[w] = 1'b1;
        checks++;
        if (w < 0 || gnt_val !== eo) begin errors++; $display("FAIL rand_grant: got %b expected %b (req %b)", gnt_val, eo, gnt_req); end
        if (w >= 0) begin
          exp_id = w;
          exp_prod = 16'(opa[w]) * 16'(opb[w]);
          pend[w] = 1'b0;
          ptr_ref = (w + 1) % N;
          in_flight = 1'b1;
        end
      end
      if (res_ev) begin
        checks++;
        if (!in_flight) begin errors++; $display("FAIL rand_spurious_res: got Res_Valid expected none"); end
        else begin
          exp_r = m_to ? 16'h0 : exp_prod;
          checks++; if (int'(Res_Id) != exp_id) begin errors++; $display("FAIL rand_id: got %0d expected %0d", Res_Id, exp_id); end
          checks++; if (Res_Err !== m_to) begin errors++; $display("FAIL rand_err: got %b expected %b", Res_Err, m_to); end
          checks++; if (Result !== exp_r) begin errors++; $display("FAIL rand_result: got %h expected %h", Result, exp_r); end
        end
        in_flight = 1'b0;
        jobs++;
      end
    end
    Req = '0;
    checks++; if (jobs < 40) begin errors++; $display("FAIL rand_jobs: got %0d expected 40", jobs); end
    repeat (3) step();
  endtask

  initial begin
    Reset = 1'b1; Req = '0; OpA_In = '0; OpB_In = '0;
    Mul_Done = 1'b0; Mul_Product = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_pass_through();
    test_timeout();
    test_reset_mid_job();
    test_req_ignored();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
